// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared definitions for the multi-channel debouncer.
//                - per-channel state encoding (IDLE, PRESS_WAIT, HELD,
//                  REL_WAIT)
//                - default timing constants for a 100 MHz clock
//                - reduced timing constants for simulation
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    // 100 MHz defaults: 50 ms filter, 500 ms hold, 100 ms repeat
    localparam int DEF_N_CH          = 4;
    localparam int DEF_STABLE_CYCLES = 5_000_000;
    localparam int DEF_CNT_W         = 23;
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    // Short timings so simulations finish quickly
    localparam int SIM_STABLE_CYCLES = 4;
    localparam int SIM_HOLD_CYCLES   = 16;
    localparam int SIM_REPEAT_CYCLES = 8;

    // True when a CNT_W-bit counter can hold the value n without wrapping
    function automatic bit fits_cnt_w(input int cnt_w, input int n);
        return (64'd1 << cnt_w) > 64'(n);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debouncer channel: 2-flop synchroniser, stability
//                filter FSM and counter, registered level and strobes.
//                Optional auto-repeat when MULTI_DEBOUNCER_AUTOREPEAT_EN is
//                defined.
//  Ports       : clk    in  system clock
//                rst    in  synchronous active-high reset
//                button in  raw asynchronous button (1 = pressed)
//                clean  out debounced level
//                rise   out 1-cycle strobe on accepted press / auto-repeat
//                fall   out 1-cycle strobe on accepted release
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;   // synchronised sample, the only input the FSM sees
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_phase;  // 0: waiting for first repeat, 1: repeating
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            clean     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
`endif
        end else begin
            sync_a <= button;
            sync_b <= sync_a;
            rise   <= 1'b0;
            fall   <= 1'b0;

            case (state)
                IDLE: begin
                    // The transition edge itself does not count toward the filter
                    if (sync_b) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!sync_b) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= HELD;
                        clean     <= 1'b1;
                        rise      <= 1'b1;
                        cnt       <= '0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                HELD: begin
                    if (!sync_b) begin
                        // Repeat counter is left untouched: a bounce back to
                        // HELD resumes where it stopped
                        state <= REL_WAIT;
                        cnt   <= '0;
                    end
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                    else if (!rpt_phase) begin
                        if (rpt_cnt == HOLD_LAST) begin
                            rise      <= 1'b1;
                            rpt_cnt   <= '0;
                            rpt_phase <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (rpt_cnt == REPEAT_LAST) begin
                            rise    <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + CNT_W'(1);
                        end
                    end
`endif
                end

                REL_WAIT: begin
                    if (sync_b) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= IDLE;
                        clean     <= 1'b0;
                        fall      <= 1'b1;
                        cnt       <= '0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_debouncer
//  Description : N-channel push-button debouncer. Each channel is an
//                independent debounce_channel producing a clean level and
//                single-cycle press/release strobes.
//                Optional feature macro: MULTI_DEBOUNCER_AUTOREPEAT_EN
//                (auto-repeat rise strobes while a button stays held). When
//                enabling it with the 100 MHz defaults, raise CNT_W so that
//                HOLD_CYCLES and REPEAT_CYCLES fit (e.g. CNT_W = 26).
//  Ports       : clk    in  system clock
//                rst    in  synchronous active-high reset
//                button in  [N_CH] raw asynchronous buttons (1 = pressed)
//                clean  out [N_CH] debounced levels
//                rise   out [N_CH] press / auto-repeat strobes
//                fall   out [N_CH] release strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    // Elaboration-time sanity checks on the timing parameters
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
        $error("multi_debouncer: timing parameters must be at least 1");
    end

    if (!fits_cnt_w(CNT_W, STABLE_CYCLES)) begin : g_bad_cnt_w_stable
        $error("multi_debouncer: CNT_W too small for STABLE_CYCLES");
    end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    if (!fits_cnt_w(CNT_W, HOLD_CYCLES) || !fits_cnt_w(CNT_W, REPEAT_CYCLES)) begin : g_bad_cnt_w_repeat
        $error("multi_debouncer: CNT_W too small for HOLD_CYCLES/REPEAT_CYCLES");
    end
`endif

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES)
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            ,
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_channel (
            .clk    (clk),
            .rst    (rst),
            .button (button[ch]),
            .clean  (clean[ch]),
            .rise   (rise[ch]),
            .fall   (fall[ch])
        );
    end

endmodule : multi_debouncer
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_debouncer
//  Description : Self-checking bench for multi_debouncer. A reference model
//                tracks, per channel, a 2-sample input delay and the number of
//                consecutive samples that disagree with the accepted level;
//                an input is accepted after STABLE+1 such samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;
    import debounce_pkg::*;

    localparam int N      = 4;
    localparam int STABLE = SIM_STABLE_CYCLES;
    localparam int HOLD   = SIM_HOLD_CYCLES;
    localparam int REP    = SIM_REPEAT_CYCLES;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] button;
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int vectors = 0;
    int errors  = 0;

    multi_debouncer #(
        .N_CH          (N),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (8),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .clean  (clean),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit           m_d1   [N];   // button one edge ago
    bit           m_d2   [N];   // button two edges ago (what the filter sees)
    bit           m_clean[N];
    int           m_run  [N];   // consecutive samples differing from clean
    int           m_held [N];   // held-time samples since press acceptance
    logic [N-1:0] exp_clean;
    logic [N-1:0] exp_rise;
    logic [N-1:0] exp_fall;

    task automatic model_edge();
        for (int ch = 0; ch < N; ch++) begin
            bit s;
            s = m_d2[ch];
            exp_rise[ch] = 1'b0;
            exp_fall[ch] = 1'b0;
            if (rst) begin
                m_d1[ch] = 0; m_d2[ch] = 0; m_clean[ch] = 0;
                m_run[ch] = 0; m_held[ch] = 0;
            end else begin
                if (s != m_clean[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == STABLE + 1) begin
                        m_clean[ch] = s;
                        if (s) exp_rise[ch] = 1'b1;
                        else   exp_fall[ch] = 1'b1;
                        m_run[ch]  = 0;
                        m_held[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                    if (m_clean[ch]) begin
                        m_held[ch]++;
                        if (m_held[ch] == HOLD ||
                            (m_held[ch] > HOLD && (m_held[ch] - HOLD) % REP == 0))
                            exp_rise[ch] = 1'b1;
                    end
`endif
                end
                m_d2[ch] = m_d1[ch];
                m_d1[ch] = button[ch];
            end
            exp_clean[ch] = m_clean[ch];
        end
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: update model, then compare outputs 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_vec("clean", clean, exp_clean);
        check_vec("rise",  rise,  exp_rise);
        check_vec("fall",  fall,  exp_fall);
    endtask

    // Run n edges; edge 0 is the first one after the call. Reports the first
    // edge index with the selected strobe on channel ch, and how many occurred.
    task automatic watch(input int ch, input bit want_fall, input int n,
                         output int first, output int count);
        first = -1;
        count = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if ((want_fall ? fall[ch] : rise[ch]) === 1'b1) begin
                if (first < 0) first = i;
                count++;
            end
        end
    endtask

    initial begin
        int first, count, exp_n, t;
        rst    = 1'b1;
        button = '0;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // 1: single press on channel 0
        button[0] = 1'b1;
        watch(0, 1'b0, 20, first, count);
        check_int("t1_rise_edge", first, STABLE + 2);
        check_int("t1_rise_count", count, 1);
        check_vec("t1_clean", clean, 4'b0001);
        button[0] = 1'b0;
        repeat (10) cycle();

        // 2: bouncing channel 1, then held
        for (int k = 0; k < 2; k++) begin
            button[1] = 1'b1; repeat (2) cycle();
            button[1] = 1'b0; repeat (2) cycle();
        end
        button[1] = 1'b1;
        watch(1, 1'b0, 12, first, count);
        check_int("t2_rise_edge", first, STABLE + 2);
        check_int("t2_rise_count", count, 1);

        // 3: clean press/release on channel 2
        button[1] = 1'b0;
        button[2] = 1'b1;
        repeat (12) cycle();
        button[2] = 1'b0;
        watch(2, 1'b1, 12, first, count);
        check_int("t3_fall_edge", first, STABLE + 2);
        check_int("t3_fall_count", count, 1);
        check_vec("t3_clean", clean, 4'b0000);

        // 4: all channels together, reset while held
        button = 4'b1111;
        count = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rise === 4'b1111) count++;
        end
        check_int("t4_all_rise", count, 1);
        rst = 1'b1;
        cycle();
        check_vec("t4_rst_clean", clean, 4'b0000);
        rst = 1'b0;
        watch(3, 1'b0, 10, first, count);
        check_int("t4_refire_edge", first, STABLE + 2);

        // 5: reset during PRESS_WAIT discards filter progress
        button = '0;
        repeat (10) cycle();
        button[0] = 1'b1;
        watch(0, 1'b0, 5, first, count);
        check_int("t5_no_early_rise", count, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        watch(0, 1'b0, 10, first, count);
        check_int("t5_refilter_edge", first, STABLE + 2);

        // 6: long hold on channel 3 (repeats only with auto-repeat)
        button = '0;
        repeat (10) cycle();
        button[3] = 1'b1;
        watch(3, 1'b0, 40, first, count);
        exp_n = 1;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
        t = STABLE + 2 + HOLD;
        while (t < 40) begin
            exp_n++;
            t += REP;
        end
`else
        t = 0;
`endif
        check_int("t6_rise_count", count, exp_n);
        button = '0;
        repeat (10) cycle();

        // Random: bouncy phase, then slower phase, occasional reset
        for (int i = 0; i < 600; i++) begin
            int odds;
            odds = (i < 300) ? 2 : 12;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(odds) == 0) button[ch] = ~button[ch];
            rst = ($urandom_range(149) == 0);
            cycle();
        end
        rst = 1'b0;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_multi_debouncer
`default_nettype wire
